// File: rtl/req_gnt_arbiter.sv
// Round-robin request/grant arbiter with a hold-time limit.
// One holder at a time. A grant ends when the holder releases (done or
// dropped req) or when it has held for MAX_HOLD cycles, which also raises
// a one-cycle timeout. One idle gap cycle always separates two grants.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no holder; arbitrate among active requests
// S_GRANT | gnt driven to the holder; hold counter running
// S_GAP   | single dead cycle after a grant ends (timeout may be high)
module req_gnt_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               timeout
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [7:0]         hold_q, hold_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               timeout_q, timeout_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic               release_now;
    logic               limit_now;

    // Round-robin search: first active request at or after ptr, wrapping.
    always_comb begin
        logic [ID_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Only the holder's own req/done bits can end a grant.
    assign release_now = done[id_q] | ~req[id_q];
    // The current cycle is the MAX_HOLD-th cycle of the grant.
    assign limit_now   = (hold_q >= (MAX_HOLD_C - 8'd1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    id_d    = win_idx;
                    hold_d  = 8'd0;
                    ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                end
            end
            S_GRANT: begin
                hold_d = (hold_q < MAX_HOLD_C) ? hold_q + 8'd1 : hold_q;
                if (release_now || limit_now) begin
                    state_d   = S_GAP;
                    gnt_d     = '0;
                    id_d      = '0;
                    // Release wins over the limit when both land together.
                    timeout_d = ~release_now;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                id_d    = '0;
            end
        endcase
    end

    // State registers; reset clears the grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            hold_q    <= 8'd0;
            gnt_q     <= '0;
            id_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;
    assign timeout   = timeout_q;

`ifndef SYNTHESIS
    default clocking cb_sva @(posedge clk);
    endclocking

    a_req_to_gnt: assert property (disable iff (!rst_n)
        (state_q == S_IDLE && req != '0) |=> gnt_valid);

    a_onehot: assert property (disable iff (!rst_n)
        $onehot0(gnt) && (gnt_valid == |gnt));

    a_gnt_needs_req: assert property (disable iff (!rst_n)
        ((gnt & ~$past(gnt) & ~$past(req)) == '0));

    c_grant: cover property (disable iff (!rst_n) gnt_valid && !$past(gnt_valid));
    c_timeout: cover property (disable iff (!rst_n) timeout);
    c_ptr_wrap: cover property (disable iff (!rst_n)
        (ptr_q == '0) && ($past(ptr_q) == ID_W'(NUM_REQ - 1)));
`endif

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Scoreboard bench for req_gnt_arbiter: directed scenarios followed by
// random traffic, all checked against a transaction-level model.
module tb_req_gnt_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;

    int n_vec = 0;
    int n_err = 0;

    // expected record: {gnt[3:0], gnt_id[1:0], gnt_valid, timeout}
    logic [7:0] exp_q[$];

    req_gnt_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who holds, for how long, whose turn is next.
    initial begin : model
        int holder;
        int held;
        bit in_gap;
        int turn;
        logic [7:0] e;
        holder = -1; held = 0; in_gap = 0; turn = 0;
        forever begin
            @(posedge clk);
            e = 8'h00;
            if (!rst_n) begin
                holder = -1; held = 0; in_gap = 0; turn = 0;
            end else if (holder >= 0) begin
                bit rel;
                held++;
                rel = done[holder] || !req[holder];
                if (rel || held == MH) begin
                    e[0]   = !rel;
                    holder = -1;
                    in_gap = 1;
                end else begin
                    e = {4'(1 << holder), 2'(holder), 1'b1, 1'b0};
                end
            end else if (in_gap) begin
                in_gap = 0;
            end else if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (holder < 0 && req[(turn + k) % N]) holder = (turn + k) % N;
                end
                turn = (holder + 1) % N;
                held = 0;
                e = {4'(1 << holder), 2'(holder), 1'b1, 1'b0};
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the queued expectation.
    initial begin : monitor
        logic [7:0] e;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {gnt, gnt_id, gnt_valid, timeout};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL cycle_outputs t=%0t got gnt=%b id=%0d valid=%b to=%b expected gnt=%b id=%0d valid=%b to=%b",
                             $time, a[7:4], a[3:2], a[1], a[0], e[7:4], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            req  = r;
            done = d;
        end
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        // Out of reset: 1010 -> holder 1; holder 1 releases on cycle 3,
        // then requester 3 gets the next grant and eventually releases.
        rst_n = 1'b1;
        req   = 4'b1010;
        done  = '0;
        drive(4'b1010, 4'b0000, 2);
        drive(4'b1010, 4'b0010, 1);
        drive(4'b1000, 4'b0000, 4);
        drive(4'b1000, 4'b1000, 1);
        drive(4'b0000, 4'b0000, 3);

        // Holder never releases: timeout after MH cycles.
        drive(4'b0001, 4'b0000, MH + 4);
        drive(4'b0000, 4'b0000, 3);

        // All requesting, each releases after one cycle; non-holder done ignored.
        drive(4'b1111, 4'b1111, 20);
        drive(4'b0000, 4'b0000, 3);

        // Release coinciding with the hold limit, plus non-holder done mid-grant.
        drive(4'b0100, 4'b0000, 2);
        drive(4'b0100, 4'b0001, 3);
        drive(4'b0100, 4'b0000, 3);
        drive(4'b0100, 4'b0100, 1);
        drive(4'b0000, 4'b0000, 3);

        // Asynchronous reset mid-grant.
        drive(4'b0010, 4'b0000, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (gnt !== '0 || gnt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_clear got gnt=%b valid=%b expected gnt=0000 valid=0", gnt, gnt_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0100;
        done  = '0;
        drive(4'b0100, 4'b0000, 3);
        drive(4'b0000, 4'b0000, 3);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] r;
            logic [N-1:0] d;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            d = '0;
            for (int b = 0; b < N; b++) d[b] = ($urandom_range(0, 4) == 0);
            drive(r, d, 1);
        end
        drive(4'b0000, 4'b0000, 4);

        n_vec++;
        if (exp_q.size() > 1) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending expected at most 1", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
